// File: rtl/cmu_cache.sv
// Direct-mapped data cache between the core data port and a variable-latency backing RAM.
// Write-back/write-allocate or write-through/no-write-allocate, with saturating hit/miss counters.
//
//   state | meaning
//   IDLE  | lookup; hits complete here, misses and write-throughs leave
//   BACK  | burst the dirty victim line out to memory
//   FILL  | burst the requested line in from memory
//   WT    | single-word write-through of the core write
module cmu_cache #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64,
    parameter bit WRITE_BACK = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, BACK, FILL, WT} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [LINES-1:0]        dirty;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES*LINE_WORDS];
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [OFF_W-1:0]        word_cnt;
    logic [OFF_W-1:0]        nxt_cnt;
    logic                    done;
    logic                    wt_hit;

    logic [TAG_W-1:0]        a_tag, r_tag;
    logic [IDX_W-1:0]        a_idx, r_idx;
    logic [OFF_W-1:0]        a_off, r_off;
    logic                    hit, go_mem, ack, last;
    logic                    data_we;
    logic [IDX_W+OFF_W-1:0]  data_waddr;
    logic [DATA_WIDTH-1:0]   data_wval;

    assign a_tag = addr[ADDR_WIDTH-1 -: TAG_W];
    assign a_idx = addr[OFF_W +: IDX_W];
    assign a_off = addr[OFF_W-1:0];
    assign r_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign r_idx = req_addr[OFF_W +: IDX_W];
    assign r_off = req_addr[OFF_W-1:0];

    assign hit     = valid[a_idx] && (tag_mem[a_idx] == a_tag);
    // done marks the re-lookup cycle after FILL/WT so that access is neither re-issued nor counted
    assign go_mem  = ram_cs && ((!WRITE_BACK && we) ? !done : !hit);
    assign stall   = ram_cs && ((state != IDLE) || go_mem);
    assign dout    = ram_cs ? data_mem[{a_idx, a_off}] : '0;
    assign ack     = mem_ack && mem_cs;
    assign last    = (word_cnt == OFF_W'(LINE_WORDS - 1));
    assign nxt_cnt = word_cnt + 1'b1;

    always_comb begin
        data_we    = 1'b0;
        data_waddr = {a_idx, a_off};
        data_wval  = din;
        case (state)
            IDLE: if (WRITE_BACK && ram_cs && we && hit) data_we = 1'b1;
            FILL: if (ack) begin
                data_we    = 1'b1;
                data_waddr = {r_idx, word_cnt};
                data_wval  = mem_rdata;
            end
            WT: if (ack && wt_hit) begin
                data_we    = 1'b1;
                data_waddr = {r_idx, r_off};
                data_wval  = mem_wdata;
            end
            default: ;
        endcase
    end

    // Data and tag arrays are deliberately not reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_waddr] <= data_wval;
        if (state == FILL && ack && last) tag_mem[r_idx] <= r_tag;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            req_addr  <= '0;
            word_cnt  <= '0;
            done      <= 1'b0;
            wt_hit    <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_cs && !go_mem && !done && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    if (WRITE_BACK && ram_cs && we && hit) dirty[a_idx] <= 1'b1;
                    if (go_mem) begin
                        req_addr <= addr;
                        word_cnt <= '0;
                        mem_cs   <= 1'b1;
                        if (!WRITE_BACK && we) begin
                            state     <= WT;
                            wt_hit    <= hit;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= din;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                            if (WRITE_BACK && valid[a_idx] && dirty[a_idx]) begin
                                state     <= BACK;
                                mem_we    <= 1'b1;
                                mem_addr  <= {tag_mem[a_idx], a_idx, {OFF_W{1'b0}}};
                                mem_wdata <= data_mem[{a_idx, {OFF_W{1'b0}}}];
                            end else begin
                                state    <= FILL;
                                mem_we   <= 1'b0;
                                mem_addr <= {a_tag, a_idx, {OFF_W{1'b0}}};
                            end
                        end
                    end
                end
                BACK: if (ack) begin
                    if (last) begin
                        dirty[r_idx] <= 1'b0;
                        state        <= FILL;
                        mem_we       <= 1'b0;
                        word_cnt     <= '0;
                        mem_addr     <= {r_tag, r_idx, {OFF_W{1'b0}}};
                    end else begin
                        word_cnt  <= nxt_cnt;
                        mem_addr  <= {tag_mem[r_idx], r_idx, nxt_cnt};
                        mem_wdata <= data_mem[{r_idx, nxt_cnt}];
                    end
                end
                FILL: if (ack) begin
                    if (last) begin
                        valid[r_idx] <= 1'b1;
                        dirty[r_idx] <= 1'b0;
                        mem_cs       <= 1'b0;
                        state        <= IDLE;
                        done         <= 1'b1;
                    end else begin
                        word_cnt <= nxt_cnt;
                        mem_addr <= {r_tag, r_idx, nxt_cnt};
                    end
                end
                WT: if (ack) begin
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                    done   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmu_cache.sv
// Bench for cmu_cache: one write-back and one write-through instance, each on a 2-cycle-ack memory.
// Directed scenarios followed by random accesses checked against an architectural cache/memory model.
module tb_cmu_cache;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst       [2];
    logic          ram_cs    [2];
    logic          we        [2];
    logic [AW-1:0] addr      [2];
    logic [DW-1:0] din       [2];
    logic [DW-1:0] dout      [2];
    logic          stall     [2];
    logic          mem_cs    [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          mem_ack   [2];
    logic [CW-1:0] hit_cnt   [2];
    logic [CW-1:0] miss_cnt  [2];

    logic [DW-1:0] mem_arr [2][256];
    logic          ack_hold [2];
    int            lat [2];
    int            xn [2];
    logic          xw [2][64];
    logic [AW-1:0] xa [2][64];
    logic [DW-1:0] xd [2][64];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmu_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(4), .LINES(4),
                .WRITE_BACK(1'b1), .CNT_WIDTH(CW)) u_wb (
        .clk(clk), .rst(rst[0]), .ram_cs(ram_cs[0]), .we(we[0]), .addr(addr[0]),
        .din(din[0]), .dout(dout[0]), .stall(stall[0]), .mem_cs(mem_cs[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0]), .hit_cnt(hit_cnt[0]),
        .miss_cnt(miss_cnt[0]));

    cmu_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(4), .LINES(4),
                .WRITE_BACK(1'b0), .CNT_WIDTH(CW)) u_wt (
        .clk(clk), .rst(rst[1]), .ram_cs(ram_cs[1]), .we(we[1]), .addr(addr[1]),
        .din(din[1]), .dout(dout[1]), .stall(stall[1]), .mem_cs(mem_cs[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1]), .hit_cnt(hit_cnt[1]),
        .miss_cnt(miss_cnt[1]));

    // Backing memory: ack two cycles after a request is seen, logging each transferred word.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_ack[k]) begin
                mem_ack[k] = 1'b0;
                lat[k] = 0;
            end else if (mem_cs[k]) begin
                lat[k]++;
                if (lat[k] >= 2 && !ack_hold[k]) begin
                    mem_ack[k] = 1'b1;
                    if (mem_we[k]) mem_arr[k][mem_addr[k]] = mem_wdata[k];
                    else mem_rdata[k] = mem_arr[k][mem_addr[k]];
                    if (xn[k] < 64) begin
                        xw[k][xn[k]] = mem_we[k];
                        xa[k][xn[k]] = mem_addr[k];
                        xd[k][xn[k]] = mem_we[k] ? mem_wdata[k] : mem_arr[k][mem_addr[k]];
                    end
                    xn[k]++;
                end
            end else begin
                lat[k] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_req(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_cs[k] = 1'b1;
        we[k]     = w;
        addr[k]   = a;
        din[k]    = d;
        #1;
    endtask

    task automatic finish_req(input int k, output logic [DW-1:0] rd, output int stalls);
        stalls = 0;
        rd = '0;
        for (int i = 0; i < 400 && stall[k]; i++) begin
            stalls++;
            tick();
        end
        chk("req_timeout", 32'(stall[k]), 32'd0);
        rd = dout[k];
        tick();
        ram_cs[k] = 1'b0;
        we[k] = 1'b0;
    endtask

    task automatic access(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int stalls);
        start_req(k, w, a, d);
        finish_req(k, rd, stalls);
    endtask

    task automatic wait_xn(input int k, input int n);
        for (int i = 0; i < 100 && xn[k] < n; i++) tick();
        chk("wait_xfer", 32'(xn[k] >= n), 32'd1);
    endtask

    task automatic pulse_reset(input int k);
        rst[k] = 1'b0;
        tick();
        rst[k] = 1'b1;
        tick();
    endtask

    // Random accesses against an architectural model: gold holds the value every address
    // must read back; mv/mt track which tag each line holds under the allocation policy.
    task automatic random_run(input int k, input bit wb, input int n);
        logic [DW-1:0] gold [256];
        bit            mv [4];
        int            mt [4];
        int            eh, em, a, idx, tg, st;
        bit            w, h;
        logic [DW-1:0] d, rd;
        pulse_reset(k);
        for (int i = 0; i < 256; i++) gold[i] = mem_arr[k][i];
        for (int i = 0; i < 4; i++) begin mv[i] = 0; mt[i] = 0; end
        eh = 0;
        em = 0;
        for (int t = 0; t < n; t++) begin
            a   = $urandom_range(0, 63);
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            idx = (a >> 2) & 3;
            tg  = a >> 4;
            h   = mv[idx] && mt[idx] == tg;
            access(k, w, AW'(a), d, rd, st);
            if (w && !wb) begin
                chk("rnd_wt_stall", 32'(st != 0), 32'd1);
            end else begin
                if (h) eh++;
                else begin
                    em++;
                    mv[idx] = 1;
                    mt[idx] = tg;
                end
                chk("rnd_stall", 32'(st != 0), 32'(!h));
            end
            if (w) gold[a] = d;
            else chk("rnd_rdata", rd, gold[a]);
            chk("rnd_hits", 32'(hit_cnt[k]), 32'(eh));
            chk("rnd_misses", 32'(miss_cnt[k]), 32'(em));
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] ma;
        int            st, h0;
        bit            stable;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; ram_cs[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; din[k] = '0;
            mem_rdata[k] = '0; mem_ack[k] = 1'b0; ack_hold[k] = 1'b0; lat[k] = 0; xn[k] = 0;
            for (int i = 0; i < 256; i++) mem_arr[k][i] = DW'(i);
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_cs", 32'(mem_cs[k]), 32'd0);
            chk("rst_stall", 32'(stall[k]), 32'd0);
            chk("rst_dout", dout[k], 32'd0);
            chk("rst_hit_cnt", 32'(hit_cnt[k]), 32'd0);
            chk("rst_miss_cnt", 32'(miss_cnt[k]), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        tick();

        // Write-back: cold read fills the line
        xn[0] = 0;
        access(0, 1'b0, 8'h10, 0, rd, st);
        chk("cold_rdata", rd, 32'h10);
        chk("cold_stalled", 32'(st > 0), 32'd1);
        chk("cold_miss_cnt", 32'(miss_cnt[0]), 32'd1);
        chk("cold_hit_cnt", 32'(hit_cnt[0]), 32'd0);
        chk("cold_xfers", 32'(xn[0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cold_fill_addr", 32'(xa[0][i]), 32'(8'h10 + i));
            chk("cold_fill_rd", 32'(xw[0][i]), 32'd0);
        end

        xn[0] = 0;
        access(0, 1'b0, 8'h13, 0, rd, st);
        chk("hit_rdata", rd, 32'h13);
        chk("hit_stalls", 32'(st), 32'd0);
        chk("hit_hit_cnt", 32'(hit_cnt[0]), 32'd1);

        access(0, 1'b1, 8'h11, 32'hDEAD, rd, st);
        chk("wrhit_stalls", 32'(st), 32'd0);
        chk("wrhit_xfers", 32'(xn[0]), 32'd0);
        chk("wrhit_hit_cnt", 32'(hit_cnt[0]), 32'd2);

        // Conflict miss evicts the dirty line first
        access(0, 1'b0, 8'h51, 0, rd, st);
        chk("evict_rdata", rd, 32'h51);
        chk("evict_miss_cnt", 32'(miss_cnt[0]), 32'd2);
        chk("evict_xfers", 32'(xn[0]), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk("back_we", 32'(xw[0][i]), 32'd1);
            chk("back_addr", 32'(xa[0][i]), 32'(8'h10 + i));
            chk("back_data", xd[0][i], (i == 1) ? 32'hDEAD : 32'(8'h10 + i));
            chk("refill_we", 32'(xw[0][4+i]), 32'd0);
            chk("refill_addr", 32'(xa[0][4+i]), 32'(8'h50 + i));
        end
        chk("backed_mem", mem_arr[0][8'h11], 32'hDEAD);

        // Memory withholds ack: request must hold still
        xn[0] = 0;
        ack_hold[0] = 1'b1;
        start_req(0, 1'b0, 8'h24, 0);
        for (int i = 0; i < 10 && !mem_cs[0]; i++) tick();
        chk("hold_req_seen", 32'(mem_cs[0]), 32'd1);
        ma = mem_addr[0];
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_addr[0] !== ma || stall[0] !== 1'b1 || mem_cs[0] !== 1'b1) stable = 1'b0;
        end
        chk("hold_addr", 32'(ma), 32'h24);
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_no_xfer", 32'(xn[0]), 32'd0);
        ack_hold[0] = 1'b0;
        finish_req(0, rd, st);
        chk("hold_rdata", rd, 32'h24);
        chk("hold_miss_cnt", 32'(miss_cnt[0]), 32'd3);

        // Core abandons its request mid-fill
        h0 = int'(hit_cnt[0]);
        xn[0] = 0;
        start_req(0, 1'b0, 8'h34, 0);
        wait_xn(0, 1);
        ram_cs[0] = 1'b0;
        for (int i = 0; i < 50 && mem_cs[0]; i++) tick();
        tick();
        chk("drop_mem_cs", 32'(mem_cs[0]), 32'd0);
        chk("drop_stall", 32'(stall[0]), 32'd0);
        chk("drop_hit_cnt", 32'(hit_cnt[0]), 32'(h0));
        chk("drop_xfers", 32'(xn[0]), 32'd4);
        access(0, 1'b0, 8'h37, 0, rd, st);
        chk("drop_then_hit", 32'(st), 32'd0);
        chk("drop_then_rdata", rd, 32'h37);
        chk("drop_then_hit_cnt", 32'(hit_cnt[0]), 32'(h0 + 1));
        chk("drop_then_miss_cnt", 32'(miss_cnt[0]), 32'd4);

        // Reset while filling word 2
        xn[0] = 0;
        start_req(0, 1'b0, 8'h44, 0);
        wait_xn(0, 2);
        @(posedge clk);
        #2;
        rst[0] = 1'b0;
        #1;
        chk("arst_mem_cs", 32'(mem_cs[0]), 32'd0);
        chk("arst_hit_cnt", 32'(hit_cnt[0]), 32'd0);
        chk("arst_miss_cnt", 32'(miss_cnt[0]), 32'd0);
        ram_cs[0] = 1'b0;
        #1;
        chk("arst_stall", 32'(stall[0]), 32'd0);
        chk("arst_dout", dout[0], 32'd0);
        tick();
        rst[0] = 1'b1;
        tick();
        access(0, 1'b0, 8'h44, 0, rd, st);
        chk("arst_remiss", 32'(st > 0), 32'd1);
        chk("arst_rdata", rd, 32'h44);
        chk("arst_miss_after", 32'(miss_cnt[0]), 32'd1);

        // Write-through: write miss goes straight to memory
        xn[1] = 0;
        access(1, 1'b1, 8'h20, 32'hBEEF, rd, st);
        chk("wt_xfers", 32'(xn[1]), 32'd1);
        chk("wt_is_write", 32'(xw[1][0]), 32'd1);
        chk("wt_addr", 32'(xa[1][0]), 32'h20);
        chk("wt_data", xd[1][0], 32'hBEEF);
        chk("wt_stalls", 32'(st), 32'd3);
        chk("wt_miss_cnt", 32'(miss_cnt[1]), 32'd0);
        chk("wt_hit_cnt", 32'(hit_cnt[1]), 32'd0);
        access(1, 1'b0, 8'h20, 0, rd, st);
        chk("wt_read_rdata", rd, 32'hBEEF);
        chk("wt_read_miss", 32'(miss_cnt[1]), 32'd1);
        xn[1] = 0;
        access(1, 1'b1, 8'h21, 32'h1234, rd, st);
        chk("wt_hitwr_xfers", 32'(xn[1]), 32'd1);
        chk("wt_hitwr_hit_cnt", 32'(hit_cnt[1]), 32'd0);
        access(1, 1'b0, 8'h21, 0, rd, st);
        chk("wt_hitrd_rdata", rd, 32'h1234);
        chk("wt_hitrd_stalls", 32'(st), 32'd0);
        chk("wt_hitrd_hit_cnt", 32'(hit_cnt[1]), 32'd1);

        random_run(0, 1'b1, 120);
        random_run(1, 1'b0, 120);

        // Hit counter saturation: hold a hitting read for 300 cycles
        access(1, 1'b0, 8'h00, 0, rd, st);
        start_req(1, 1'b0, 8'h00, 0);
        for (int i = 0; i < 300; i++) tick();
        chk("hit_saturate", 32'(hit_cnt[1]), 32'hFF);
        ram_cs[1] = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
